wb4_fifo_reader: RTL and testbench

WB4_FIFO_READER -- requirements
Module: wb4_fifo_reader

---
 rtl/wb4_fifo_reader_if.sv | 24 ++
 rtl/wb4_fifo_reader.sv | 130 +++++++++++++
 tb/tb_wb4_fifo_reader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb4_fifo_reader_if.sv
// Bus bundle for wb4_fifo_reader: the WB4 pipelined read port plus the
// downstream valid/ready stream. Signal names keep the original port names.
interface wb4_fifo_reader_if #(
  parameter int unsigned P_DATA_MSB = 7
);
  logic              o_wb4_cyc;
  logic              o_wb4_stb;
  logic              i_wb4_stall;
  logic              i_wb4_ack;
  logic [P_DATA_MSB:0] i_wb4_data;
  logic              o_tvalid;
  logic [P_DATA_MSB:0] o_tdata;
  logic              i_tready;

  modport master (
    output o_wb4_cyc, o_wb4_stb, o_tvalid, o_tdata,
    input  i_wb4_stall, i_wb4_ack, i_wb4_data, i_tready
  );

  modport slave (
    input  o_wb4_cyc, o_wb4_stb, o_tvalid, o_tdata,
    output i_wb4_stall, i_wb4_ack, i_wb4_data, i_tready
  );
endinterface

// File: rtl/wb4_fifo_reader.sv
// WB4 pipelined read master that pulls words from an upstream FIFO slave and
// forwards them through a small response buffer onto a valid/ready stream.
// Requests are credit-limited so the buffer can absorb every outstanding ack.
module wb4_fifo_reader #(
  parameter int unsigned P_DATA_MSB  = 7,
  parameter int unsigned P_BUF_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  wb4_fifo_reader_if.master    bus,
  output logic                 o_idle,
  output logic                 o_err
);

  localparam int unsigned AW = $clog2(P_BUF_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(P_BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t              state;
  logic [P_DATA_MSB:0] mem [P_BUF_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [CW-1:0]       outstanding;
  logic [CW-1:0]       count_next;
  logic [CW-1:0]       out_next;
  logic [CW:0]         credit_sum;
  logic                accept;
  logic                push;
  logic                pop;
  logic                unexp_ack;
  logic                has_credit;

  // Handshake decode and next-cycle occupancy used by the credit check
  always_comb begin
    accept     = bus.o_wb4_stb & ~bus.i_wb4_stall;
    push       = bus.i_wb4_ack & (outstanding != '0);
    unexp_ack  = bus.i_wb4_ack & (outstanding == '0);
    pop        = bus.o_tvalid & bus.i_tready;
    out_next   = outstanding;
    count_next = count;
    if (accept && !push)
      out_next = outstanding + CW'(1);
    else if (!accept && push)
      out_next = outstanding - CW'(1);
    if (push && !pop)
      count_next = count + CW'(1);
    else if (!push && pop)
      count_next = count - CW'(1);
    // A strobe raised now can be accepted next cycle, so it needs one free slot
    // beyond everything already in flight or buffered.
    credit_sum = {1'b0, out_next} + {1'b0, count_next};
    has_credit = (credit_sum < DEPTH_V);
  end

  // Bus state machine with registered cyc/stb/idle/err
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      bus.o_wb4_cyc <= 1'b0;
      bus.o_wb4_stb <= 1'b0;
      o_idle        <= 1'b1;
      o_err         <= 1'b0;
    end else begin
      o_err <= unexp_ack;
      case (state)
        IDLE: begin
          if (i_enable) begin
            state         <= ACTIVE;
            bus.o_wb4_cyc <= 1'b1;
            bus.o_wb4_stb <= has_credit;
            o_idle        <= 1'b0;
          end
        end
        ACTIVE: begin
          if (!i_enable) begin
            state         <= DRAIN;
            bus.o_wb4_stb <= 1'b0;
          end else begin
            bus.o_wb4_stb <= has_credit;
          end
        end
        DRAIN: begin
          bus.o_wb4_stb <= 1'b0;
          if (out_next == '0) begin
            state         <= IDLE;
            bus.o_wb4_cyc <= 1'b0;
            o_idle        <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.o_wb4_cyc <= 1'b0;
          bus.o_wb4_stb <= 1'b0;
          o_idle        <= 1'b1;
        end
      endcase
    end
  end

  // Outstanding-request counter and buffer pointers/occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      outstanding <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= out_next;
      count       <= count_next;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Response buffer storage; contents are don't-care until counted valid
  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_ptr] <= bus.i_wb4_data;
  end

  assign bus.o_tvalid = (count != '0);
  assign bus.o_tdata  = mem[rd_ptr];

endmodule

// File: tb/tb_wb4_fifo_reader.sv
// Self-checking bench for wb4_fifo_reader: a behavioural WB4 slave feeds
// counting data, and a scoreboard of acked words is compared to the stream.
module tb_wb4_fifo_reader;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic idle;
  logic err;

  wb4_fifo_reader_if #(.P_DATA_MSB(7)) bus ();

  wb4_fifo_reader #(.P_DATA_MSB(7), .P_BUF_DEPTH(4)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_enable(enable),
    .bus     (bus),
    .o_idle  (idle),
    .o_err   (err)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [7:0] sb[$];
  logic [7:0] next_data;
  logic       stall_ctl;
  logic       ack_en;
  logic       extra_ack;
  logic [7:0] extra_data;
  int unsigned pend;

  // One bus cycle: sample outputs at the falling edge, then drive the slave
  // side for the next rising edge. Acks follow accepts by one cycle.
  task automatic tick(output bit popped, output logic [7:0] pdata, output bit acc);
    @(negedge clk);
    popped = bus.o_tvalid && bus.i_tready && !rst;
    pdata  = bus.o_tdata;
    if (rst) pend = 0;
    if (extra_ack) begin
      bus.i_wb4_ack  = 1'b1;
      bus.i_wb4_data = extra_data;
      extra_ack      = 1'b0;
    end else if (ack_en && pend > 0 && !rst) begin
      bus.i_wb4_ack  = 1'b1;
      bus.i_wb4_data = next_data;
      sb.push_back(next_data);
      next_data = next_data + 8'd1;
      pend--;
    end else begin
      bus.i_wb4_ack  = 1'b0;
      bus.i_wb4_data = 8'h00;
    end
    bus.i_wb4_stall = stall_ctl;
    acc = bus.o_wb4_stb && !stall_ctl && !rst;
    if (acc) pend++;
  endtask

  task automatic do_reset();
    bit p; logic [7:0] pd; bit a;
    enable = 1'b0; stall_ctl = 1'b0; ack_en = 1'b1; extra_ack = 1'b0;
    bus.i_tready = 1'b0;
    rst = 1'b1;
    tick(p, pd, a);
    tick(p, pd, a);
    rst = 1'b0;
    sb.delete();
    pend = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.o_wb4_cyc !== 1'b0) begin fails++; $display("FAIL reset_cyc got %b exp 0", bus.o_wb4_cyc); end
    tests++; if (bus.o_wb4_stb !== 1'b0) begin fails++; $display("FAIL reset_stb got %b exp 0", bus.o_wb4_stb); end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle got %b exp 1", idle); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err); end
    tests++; if (bus.o_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got %b exp 0", bus.o_tvalid); end
  endtask

  task automatic test_stream();
    bit p; logic [7:0] pd; bit a;
    logic [7:0] exp;
    int npop = 0, first = -1, last = -1, nerr = 0;
    do_reset();
    next_data = 8'h01; bus.i_tready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 80 && npop < 8; i++) begin
      tick(p, pd, a);
      if (err) nerr++;
      if (p) begin
        exp = 8'hxx;
        if (sb.size() > 0) exp = sb.pop_front();
        tests++;
        if (pd !== exp || exp !== 8'(npop + 1)) begin
          fails++; $display("FAIL stream_data got %h exp %h", pd, 8'(npop + 1));
        end
        if (first < 0) first = i;
        last = i;
        npop++;
      end
    end
    tests++; if (npop != 8) begin fails++; $display("FAIL stream_count got %0d exp 8", npop); end
    tests++; if (last - first != 7) begin fails++; $display("FAIL stream_gapless got span %0d exp 7", last - first); end
    tests++; if (nerr != 0) begin fails++; $display("FAIL stream_err got %0d pulses exp 0", nerr); end
  endtask

  task automatic test_credit();
    bit p; logic [7:0] pd; bit a;
    int naccept = 0;
    do_reset();
    next_data = 8'h10; enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(p, pd, a);
      if (a) naccept++;
    end
    tests++; if (naccept != 4) begin fails++; $display("FAIL credit_accepts got %0d exp 4", naccept); end
    tests++; if (bus.o_wb4_stb !== 1'b0) begin fails++; $display("FAIL credit_stb got %b exp 0", bus.o_wb4_stb); end
    tests++; if (bus.o_tvalid !== 1'b1) begin fails++; $display("FAIL credit_tvalid got %b exp 1", bus.o_tvalid); end
    tests++; if (bus.o_tdata !== 8'h10) begin fails++; $display("FAIL credit_tdata got %h exp 10", bus.o_tdata); end
    tests++; if (sb.size() != 4) begin fails++; $display("FAIL credit_buffered got %0d exp 4", sb.size()); end
  endtask

  task automatic test_stall();
    bit p; logic [7:0] pd; bit a;
    logic [7:0] exp;
    int held = 0, naccept = 0, nerr = 0, cyc_hi = 0;
    bit seen = 0, reached = 0;
    do_reset();
    next_data = 8'h40; ack_en = 1'b0; stall_ctl = 1'b1; bus.i_tready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(p, pd, a);
      seen = bus.o_wb4_stb;
    end
    tests++; if (!seen) begin fails++; $display("FAIL stall_stb_rise got 0 exp 1"); end
    for (int i = 0; i < 5; i++) begin
      tick(p, pd, a);
      if (a) naccept++;
      if (bus.o_wb4_stb) held++;
    end
    tests++; if (held != 5) begin fails++; $display("FAIL stall_stb_held got %0d exp 5", held); end
    tests++; if (naccept != 0) begin fails++; $display("FAIL stall_no_accept got %0d exp 0", naccept); end
    stall_ctl = 1'b0;
    tick(p, pd, a);
    tests++; if (!a) begin fails++; $display("FAIL stall_accept got 0 exp 1"); end
    stall_ctl = 1'b1; enable = 1'b0;
    tick(p, pd, a);
    for (int i = 0; i < 3; i++) begin
      tick(p, pd, a);
      if (bus.o_wb4_cyc) cyc_hi++;
    end
    tests++; if (cyc_hi != 3) begin fails++; $display("FAIL stall_one_outstanding got cyc %0d/3 exp 3", cyc_hi); end
    ack_en = 1'b1;
    for (int i = 0; i < 6 && !(reached && !bus.o_tvalid); i++) begin
      tick(p, pd, a);
      if (err) nerr++;
      if (idle) reached = 1;
      if (p) begin
        exp = 8'hxx;
        if (sb.size() > 0) exp = sb.pop_front();
        tests++; if (pd !== exp || exp !== 8'h40) begin fails++; $display("FAIL stall_data got %h exp 40", pd); end
      end
    end
    tests++; if (!reached || nerr != 0) begin fails++; $display("FAIL stall_idle got idle %b err %0d exp idle 1 err 0", reached, nerr); end
  endtask

  task automatic test_drain();
    bit p; logic [7:0] pd; bit a;
    logic [7:0] exp;
    int naccept = 0, ok = 0;
    bit reached = 0;
    do_reset();
    next_data = 8'h60; ack_en = 1'b0; bus.i_tready = 1'b1; enable = 1'b1;
    for (int i = 0; i < 10 && naccept < 2; i++) begin
      tick(p, pd, a);
      if (a) naccept++;
    end
    stall_ctl = 1'b1; enable = 1'b0;
    tick(p, pd, a);
    for (int i = 0; i < 3; i++) begin
      tick(p, pd, a);
      if (bus.o_wb4_cyc && !bus.o_wb4_stb && !idle) ok++;
    end
    tests++; if (naccept != 2 || ok != 3) begin fails++; $display("FAIL drain_hold got accepts %0d ok %0d exp 2 3", naccept, ok); end
    ack_en = 1'b1;
    tick(p, pd, a);
    tick(p, pd, a);
    tests++; if (bus.o_wb4_cyc !== 1'b1) begin fails++; $display("FAIL drain_cyc_after_ack1 got %b exp 1", bus.o_wb4_cyc); end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick(p, pd, a);
      if (idle && !bus.o_wb4_cyc) reached = 1;
      if (p) begin
        exp = 8'hxx;
        if (sb.size() > 0) exp = sb.pop_front();
        tests++; if (pd !== exp) begin fails++; $display("FAIL drain_data got %h exp %h", pd, exp); end
      end
    end
    tests++; if (!reached) begin fails++; $display("FAIL drain_idle got 0 exp 1"); end
    tests++; if (next_data !== 8'h62) begin fails++; $display("FAIL drain_acks got %h exp 62", next_data); end
  endtask

  task automatic test_unexpected_ack();
    bit p; logic [7:0] pd; bit a;
    do_reset();
    extra_data = 8'hAA; extra_ack = 1'b1;
    tick(p, pd, a);
    tick(p, pd, a);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL unexp_err got %b exp 1", err); end
    tests++; if (bus.o_tvalid !== 1'b0) begin fails++; $display("FAIL unexp_tvalid got %b exp 0", bus.o_tvalid); end
    tick(p, pd, a);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL unexp_err_pulse got %b exp 0", err); end
    tests++; if (bus.o_tvalid !== 1'b0) begin fails++; $display("FAIL unexp_tvalid2 got %b exp 0", bus.o_tvalid); end
  endtask

  task automatic test_reset_mid();
    bit p; logic [7:0] pd; bit a;
    do_reset();
    next_data = 8'h80; enable = 1'b1;
    for (int i = 0; i < 20 && sb.size() < 3; i++) tick(p, pd, a);
    tests++; if (sb.size() < 3 || bus.o_tvalid !== 1'b1) begin fails++; $display("FAIL midrst_fill got %0d exp 3", sb.size()); end
    rst = 1'b1;
    tick(p, pd, a);
    rst = 1'b0; enable = 1'b0;
    tests++; if (bus.o_tvalid !== 1'b0) begin fails++; $display("FAIL midrst_tvalid got %b exp 0", bus.o_tvalid); end
    tests++; if (bus.o_wb4_cyc !== 1'b0) begin fails++; $display("FAIL midrst_cyc got %b exp 0", bus.o_wb4_cyc); end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL midrst_idle got %b exp 1", idle); end
    sb.delete();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; stall_ctl = 1'b0; ack_en = 1'b1; extra_ack = 1'b0;
    extra_data = 8'h00; next_data = 8'h00; pend = 0;
    bus.i_wb4_stall = 1'b0; bus.i_wb4_ack = 1'b0; bus.i_wb4_data = 8'h00; bus.i_tready = 1'b0;
    test_reset();
    test_stream();
    test_credit();
    test_stall();
    test_drain();
    test_unexpected_ack();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
